fetch_stage: RTL

- Instruction-fetch stage of the 5-stage MIPS pipeline; the producer of the `inst` word that the decode stage consumes.
- Holds the PC and issues word reads to instruction memory over a valid/ready request port with an in-order response port.
- Buffers returned instructions in a small FIFO and presents them to decode with a valid/ready handshake.
- Handles control-flow redirects (taken branch from EX, jump from ID): flushes the FIFO and discards stale in-flight responses.

---
 rtl/fetch_stage.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the 5-stage MIPS pipeline.
// Owns the PC, issues word reads to instruction memory over a valid/ready
// request port, collects in-order responses into a small instruction buffer
// and presents them to decode with a valid/ready handshake.
// Redirects (taken branch from EX, jump from ID) flush the buffer and
// discard responses that were already in flight to the old path.
// Optional build macro FETCH_PERF_EN adds redirect / dropped-instruction
// performance counters (perf_redirects, perf_dropped).

module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,

    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc_plus4,

    input  logic        branch_taken,
    input  logic [31:0] branch_pc_plus4,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic [31:0] jump_pc_plus4
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_redirects,
    output logic [31:0] perf_dropped
`endif
);

    // Pointer width for the buffer and tag queue, and a counter width that
    // can hold the value FIFO_DEPTH itself.
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_WIDE = (CW + 1)'(FIFO_DEPTH);

    // Architectural fetch state.
    logic [31:0]   pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] dropCnt;

    // Instruction buffer: data word and PC+4 of each entry.
    logic [31:0]   instMem  [FIFO_DEPTH];
    logic [31:0]   pcMem    [FIFO_DEPTH];
    logic [PW-1:0] headPtr;
    logic [PW-1:0] tailPtr;
    logic [CW-1:0] fifoCount;

    // Tag queue: fetch address of every request still awaiting a response.
    logic [31:0]   tagMem   [FIFO_DEPTH];
    logic [PW-1:0] tagHead;
    logic [PW-1:0] tagTail;

    // Combinational control.
    logic          redirect;
    logic [31:0]   branchTarget;
    logic [31:0]   jumpTarget;
    logic [31:0]   redirectTarget;
    logic [CW:0]   inFlight;
    logic          reqFire;
    logic          rspAccept;
    logic          rspDrop;
    logic          push;
    logic          pop;
    logic [31:0]   pushPcPlus4;

    // Redirect targets, credit-based issue and handshake decode. Nothing is
    // requested or presented while reset is held, because the memory is
    // reset by the same signal and would lose the request.
    always_comb begin
        redirect       = branch_taken | jump;
        branchTarget   = branch_pc_plus4 + (branch_offset << 2);
        jumpTarget     = (jump_pc_plus4 & 32'hF000_0000) | {4'b0000, jump_index, 2'b00};
        redirectTarget = branch_taken ? branchTarget : jumpTarget;

        inFlight       = {1'b0, fifoCount} + {1'b0, outstanding};

        imem_req_valid = rst_n && !redirect && (inFlight < DEPTH_WIDE);
        imem_addr      = pc;
        reqFire        = imem_req_valid && imem_req_ready;

        rspAccept      = imem_rsp_valid && (outstanding != '0);
        rspDrop        = rspAccept && (redirect || (dropCnt != '0));
        push           = rspAccept && !redirect && (dropCnt == '0);
        pushPcPlus4    = tagMem[tagHead] + 32'd4;

        inst_valid     = rst_n && !redirect && (fifoCount != '0);
        pop            = inst_valid && inst_ready;
        inst           = instMem[headPtr];
        inst_pc_plus4  = pcMem[headPtr];
    end

    // PC, outstanding-request count and stale-response drop counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            dropCnt     <= '0;
        end else begin
            if (redirect) begin
                pc <= redirectTarget;
            end else if (reqFire) begin
                pc <= pc + 32'd4;
            end

            case ({reqFire, rspAccept})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase

            if (redirect) begin
                dropCnt <= outstanding - (rspAccept ? CW'(1) : CW'(0));
            end else if (rspDrop) begin
                dropCnt <= dropCnt - CW'(1);
            end
        end
    end

    // Instruction buffer: push accepted responses, pop on decode handshake,
    // clear everything on a redirect.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            headPtr   <= '0;
            tailPtr   <= '0;
            fifoCount <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                instMem[i] <= '0;
                pcMem[i]   <= '0;
            end
        end else if (redirect) begin
            headPtr   <= '0;
            tailPtr   <= '0;
            fifoCount <= '0;
        end else begin
            if (push) begin
                instMem[tailPtr] <= imem_rsp_data;
                pcMem[tailPtr]   <= pushPcPlus4;
                tailPtr          <= tailPtr + PW'(1);
            end
            if (pop) begin
                headPtr <= headPtr + PW'(1);
            end
            case ({push, pop})
                2'b10:   fifoCount <= fifoCount + CW'(1);
                2'b01:   fifoCount <= fifoCount - CW'(1);
                default: fifoCount <= fifoCount;
            endcase
        end
    end

    // Tag queue follows requests and responses one-for-one, including the
    // ones that get dropped, so the head always matches the next response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tagHead <= '0;
            tagTail <= '0;
        end else begin
            if (reqFire) begin
                tagMem[tagTail] <= pc;
                tagTail         <= tagTail + PW'(1);
            end
            if (rspAccept) begin
                tagHead <= tagHead + PW'(1);
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [32:0] redirectSum;
    logic [32:0] droppedSum;

    // Saturating next values for the performance counters. Flushed buffer
    // entries and discarded responses both count as dropped instructions.
    always_comb begin
        redirectSum = {1'b0, perf_redirects} + 33'(redirect);
        droppedSum  = {1'b0, perf_dropped} + 33'(rspDrop)
                    + (redirect ? 33'(fifoCount) : 33'd0);
    end

    // Performance counters, clamped at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_redirects <= '0;
            perf_dropped   <= '0;
        end else begin
            perf_redirects <= redirectSum[32] ? 32'hFFFF_FFFF : redirectSum[31:0];
            perf_dropped   <= droppedSum[32]  ? 32'hFFFF_FFFF : droppedSum[31:0];
        end
    end
`endif

endmodule
